sub_serial: RTL and testbench
=============================

# sub_serial

Bit-serial unsigned subtractor: the inverse arithmetic path of the team's bit-serial adder, sharing its start/complete protocol. One start request latches two W-bit operands and computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flop. It then holds the difference and final borrow until the next start. It sits beside the serial adder in the datapath, so controllers can issue add or subtract with identical sequencing.

## Interface
- `W`, default 8: operand and result width; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high; clears all state.
- `en`  in  1  start request in IDLE; acknowledge and release in DONE.
- `a`  in  W  minuend, sampled only on the IDLE→SUB edge.
- `b`  in  W  subtrahend, sampled only on the IDLE→SUB edge.
- `out`  out  W  difference `(a - b) mod 2^W`; valid while `done`=1.
- `done`  out  1  high exactly while the FSM is in DONE.
- `borrow`  out  1  final borrow; 1 means a < b (underflow); valid while `done`=1.

Reset values: `out`=0, `done`=0, `borrow`=0; internal state=IDLE, count=0, a_reg=0, b_reg=0.

## Operation
- State encoding is 2 bits: IDLE=0, SUB=1, DONE=2. Encoding 3 is unreachable and must go to IDLE.
- IDLE:
  - If `en`=1: load a_reg←a and b_reg←b, clear out←0, borrow←0 and count←0, then go to SUB.
  - If `en`=0: all registers hold.
- SUB, once per cycle:
  - d = a_reg[0] ^ b_reg[0] ^ borrow.
  - borrow ← (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow).
  - out ← {d, out[W-1:1]}.
  - a_reg and b_reg shift right by 1 with zero fill; count increments.
  - `en` is ignored in SUB.
- SUB ends when count == W-1; that cycle performs the last bit, and the next state is DONE.
- DONE:
  - out, borrow and count hold.
  - `en`=1 goes to IDLE. The request is not a restart: a new operation needs `en` sampled in IDLE.
  - `en`=0 stays in DONE.
- Arithmetic: out equals the low W bits of a - b, and borrow equals (a < b). Signed interpretation is the user's responsibility; an overflow flag is not provided.
- `a` and `b` may change freely after the start edge.

## Timing
- The start edge (IDLE with `en`=1) is edge 0. SUB occupies edges 1..W, and `done` rises after edge W. Total latency is W+1 clocks from the start edge.
- `done` is a registered state decode and has no combinational path from `en`.
- If `en` is held high continuously, the sequence is IDLE→SUB×W→DONE→IDLE→SUB…, giving a throughput of one result per W+2 cycles.
- Reset asserted mid-SUB or in DONE clears everything asynchronously; the partial result is lost and `done` drops immediately.
- Release of `rst` must be synchronous to `clk` at system level; the block performs no internal synchronization.

## Configuration
- `SUB_SERIAL_SAT_EN`
  - Defined: on the final SUB cycle, if the computed next borrow is 1, out ← 0 instead of the shifted value. The result saturates at zero, and `borrow` is still reported as 1.
  - Undefined: wrap-around result as specified above. The saturation logic is absent.

## Test plan
- W=8, a=200, b=55, pulse `en` -> `done` after 9 clocks; out=145, borrow=0.
- W=8, a=5, b=10 -> out=251 and borrow=1. With `SUB_SERIAL_SAT_EN` defined: out=0, borrow=1.
- W=8, a=255, b=255, then a=0, b=0 -> out=0 and borrow=0 both times; a=0, b=1 -> out=255, borrow=1.
- Change a and b on every cycle during SUB -> result matches the values latched at the start edge.
- Assert `rst` at SUB cycle 4 -> `out`, `done` and `borrow` are 0 immediately. A new start after release gives a correct result.
- Hold `en`=1 for 40 cycles with a=100, b=1 -> `done` pulses once every 10 cycles, with out=99 each time.

Source files
------------

// File: rtl/sub_serial_if.sv
// sub_serial_if: start/complete handshake and operand/result bus for the
// bit-serial subtractor. The master issues requests and the slave computes.
interface sub_serial_if #(
   parameter int unsigned W = 8
);
   logic         en;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] out;
   logic         done;
   logic         borrow;

   modport master (
      output en, a, b,
      input  out, done, borrow
   );

   modport slave (
      input  en, a, b,
      output out, done, borrow
   );
endinterface

// File: rtl/sub_serial.sv
// sub_serial: bit-serial unsigned subtractor, LSB first, one full-subtractor
// cell plus a borrow flop. Result is out = (a - b) mod 2^W and borrow = (a < b).
// Optional feature macro: SUB_SERIAL_SAT_EN (saturate the result at zero on
// underflow; borrow is still reported).
module sub_serial #(
   parameter int unsigned W = 8
) (
   input  logic          clk,
   input  logic          rst,
   sub_serial_if.slave   bus
);

   localparam int unsigned CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [W-1:0]  out_q;
   logic          borrow_q;
   logic          done_q;

   logic          diff_c;
   logic          borrow_nxt_c;
   logic          last_c;
   logic [W-1:0]  out_shift_c;

   // Full-subtractor cell on the current LSBs and shift-in of the difference bit
   always_comb begin
      diff_c       = a_reg[0] ^ b_reg[0] ^ borrow_q;
      borrow_nxt_c = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow_q);
      last_c       = (count == CW'(W - 1));
      out_shift_c  = {diff_c, out_q[W-1:1]};
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         out_q    <= '0;
         borrow_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.en) begin
                  a_reg    <= bus.a;
                  b_reg    <= bus.b;
                  out_q    <= '0;
                  borrow_q <= 1'b0;
                  count    <= '0;
                  state    <= SUB;
               end
            end
            SUB: begin
`ifdef SUB_SERIAL_SAT_EN
               // Clamp to zero when the final bit leaves a borrow outstanding
               if (last_c && borrow_nxt_c) begin
                  out_q <= '0;
               end else begin
                  out_q <= out_shift_c;
               end
`else
               out_q <= out_shift_c;
`endif
               borrow_q <= borrow_nxt_c;
               a_reg    <= {1'b0, a_reg[W-1:1]};
               b_reg    <= {1'b0, b_reg[W-1:1]};
               count    <= count + CW'(1);
               if (last_c) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               // en here only releases the result; a restart needs en in IDLE
               if (bus.en) begin
                  state  <= IDLE;
                  done_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out    = out_q;
   assign bus.borrow = borrow_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed self-checking bench for sub_serial (W=8).
module tb_sub_serial;

   localparam int unsigned W = 8;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   sub_serial_if #(.W(W)) bus ();

   sub_serial #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Start an operation, wait for done, check latency/result, then release
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] eo, input logic eb,
                         input bit scramble, input string tag);
      int cyc;
      logic [7:0] held;
      @(negedge clk);
      bus.en = 1'b1;
      bus.a  = av;
      bus.b  = bv;
      @(negedge clk);
      bus.en = 1'b0;
      cyc = 1;
      while (!bus.done && cyc < 30) begin
         if (scramble) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      check({tag, "_lat"}, 32'(cyc), 32'd9);
      check({tag, "_out"}, 32'(bus.out), 32'(eo));
      check({tag, "_borrow"}, 32'(bus.borrow), 32'(eb));
      held = bus.out;
      @(negedge clk);
      check({tag, "_hold_done"}, 32'(bus.done), 32'd1);
      check({tag, "_hold_out"}, 32'(bus.out), 32'(held));
      bus.en = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      check({tag, "_release"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int pulses;
      int last_pulse;
      errors  = 0;
      checks  = 0;
      rst     = 1'b1;
      bus.en  = 1'b0;
      bus.a   = '0;
      bus.b   = '0;
      repeat (2) @(negedge clk);
      check("rst_out", 32'(bus.out), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_borrow", 32'(bus.borrow), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(8'd200, 8'd55, 8'd145, 1'b1 ^ 1'b1, 1'b0, "200m55");
`ifdef SUB_SERIAL_SAT_EN
      run_op(8'd5, 8'd10, 8'd0, 1'b1, 1'b0, "5m10");
`else
      run_op(8'd5, 8'd10, 8'd251, 1'b1, 1'b0, "5m10");
`endif
      run_op(8'd255, 8'd255, 8'd0, 1'b0, 1'b0, "255m255");
      run_op(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, "0m0");
`ifdef SUB_SERIAL_SAT_EN
      run_op(8'd0, 8'd1, 8'd0, 1'b1, 1'b0, "0m1");
      run_op(8'd33, 8'd77, 8'd0, 1'b1, 1'b1, "scr_33m77");
`else
      run_op(8'd0, 8'd1, 8'd255, 1'b1, 1'b0, "0m1");
      run_op(8'd33, 8'd77, 8'd212, 1'b1, 1'b1, "scr_33m77");
`endif
      run_op(8'd77, 8'd33, 8'd44, 1'b0, 1'b1, "scr_77m33");

      // Asynchronous reset in the middle of SUB
      @(negedge clk);
      bus.en = 1'b1;
      bus.a  = 8'd200;
      bus.b  = 8'd55;
      @(negedge clk);
      bus.en = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_sub_partial_nonzero", 32'(bus.out != '0), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out", 32'(bus.out), 32'd0);
      check("mid_rst_done", 32'(bus.done), 32'd0);
      check("mid_rst_borrow", 32'(bus.borrow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post_rst_idle", 32'(bus.done), 32'd0);
      run_op(8'd200, 8'd55, 8'd145, 1'b0, 1'b0, "after_rst");

      // Asynchronous reset while holding a result in DONE
      @(negedge clk);
      bus.en = 1'b1;
      bus.a  = 8'd0;
      bus.b  = 8'd1;
      @(negedge clk);
      bus.en = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_rst_done", 32'(bus.done), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("done_rst_done", 32'(bus.done), 32'd0);
      check("done_rst_out", 32'(bus.out), 32'd0);
      check("done_rst_borrow", 32'(bus.borrow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // en held high: one result every W+2 cycles
      pulses     = 0;
      last_pulse = -1;
      bus.a  = 8'd100;
      bus.b  = 8'd1;
      bus.en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) begin
            check("stream_out", 32'(bus.out), 32'd99);
            check("stream_borrow", 32'(bus.borrow), 32'd0);
            if (last_pulse >= 0) begin
               check("stream_period", 32'(i - last_pulse), 32'd10);
            end
            last_pulse = i;
            pulses++;
         end
      end
      bus.en = 1'b0;
      check("stream_pulses", 32'(pulses), 32'd4);
      repeat (2) @(negedge clk);
      check("stream_idle", 32'(bus.done), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
